// File: rtl/shift_counter_gen.sv
// Ring / Johnson shift counter with parallel load and self-correction.
// An illegal state is detected on an enabled shift and replaced by the mode's home state.
module shift_counter_gen #(
    parameter int WIDTH    = 4,
    parameter int INIT_POS = WIDTH-1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             dir,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] out,
    output logic             wrap,
    output logic             err
);

    localparam logic [WIDTH-1:0] RING_SEED = WIDTH'(1) << INIT_POS;
    localparam logic [WIDTH-1:0] JOHN_HOME = '0;

    logic             john;
    logic             ring_ok;
    logic             john_ok;
    logic             legal;
    logic [WIDTH-1:0] home;
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] out_nxt;
    logic             wrap_nxt;
    logic             err_nxt;

    // Ring: exactly one bit set. Johnson: at most one adjacent-bit transition.
    always_comb begin
        int ones;
        int edges;
        ones  = 0;
        edges = 0;
        for (int i = 0; i < WIDTH; i++)
            ones = ones + int'(out[i]);
        for (int i = 0; i < WIDTH-1; i++)
            edges = edges + int'(out[i] ^ out[i+1]);
        ring_ok = (ones == 1);
        john_ok = (edges <= 1);
    end

    // mode[0] selects Johnson: the wrapped-around bit is inverted.
    always_comb begin
        john = mode[0];
        if (dir)
            shifted = {out[WIDTH-2:0], out[WIDTH-1] ^ john};
        else
            shifted = {out[0] ^ john, out[WIDTH-1:1]};
        legal = john ? john_ok : ring_ok;
        home  = john ? JOHN_HOME : RING_SEED;
    end

    always_comb begin
        out_nxt  = out;
        wrap_nxt = 1'b0;
        err_nxt  = 1'b0;
        if (load) begin
            out_nxt = load_val;
        end else if (en && !mode[1]) begin
            if (!legal) begin
                out_nxt = home;
                err_nxt = 1'b1;
            end else begin
                out_nxt  = shifted;
                wrap_nxt = (shifted == home);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out  <= RING_SEED;
            wrap <= 1'b0;
            err  <= 1'b0;
        end else begin
            out  <= out_nxt;
            wrap <= wrap_nxt;
            err  <= err_nxt;
        end
    end

endmodule

// File: tb/tb_shift_counter_gen.sv
// Randomized + directed bench for shift_counter_gen (WIDTH=4) against a
// behavioural model built from arithmetic shifts and a reachable-state table.
module tb_shift_counter_gen;

    localparam int W = 4;
    localparam logic [W-1:0] SEED = 4'b1000;
    localparam logic [W-1:0] MASK = 4'b1111;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         en = 1'b0;
    logic [1:0]   mode = 2'b00;
    logic         dir = 1'b0;
    logic         load = 1'b0;
    logic [W-1:0] load_val = '0;
    logic [W-1:0] out;
    logic         wrap;
    logic         err;

    int total = 0;
    int bad = 0;

    logic [W-1:0] m_out = SEED;
    logic         m_wrap = 1'b0;
    logic         m_err = 1'b0;
    bit           jlegal [16];

    logic [W-1:0] exp29 [4] = '{4'b0100, 4'b0010, 4'b0001, 4'b1000};
    logic [W-1:0] exp30 [8] = '{4'b1000, 4'b1100, 4'b1110, 4'b1111,
                                4'b0111, 4'b0011, 4'b0001, 4'b0000};
    logic [W-1:0] exp32 [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};

    shift_counter_gen #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .dir(dir),
        .load(load), .load_val(load_val), .out(out), .wrap(wrap), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] jshift_right(input logic [W-1:0] v);
        return (v >> 1) | (((~v) & 4'd1) << (W-1));
    endfunction

    // Next state from the rules: priority load > hold > shift > idle.
    task automatic mnext();
        logic [W-1:0] v;
        logic         ok;
        m_wrap = 1'b0;
        m_err  = 1'b0;
        if (load) begin
            m_out = load_val;
        end else if (en && mode < 2) begin
            if (mode == 0) ok = (m_out != 0) && ((m_out & (m_out - 4'd1)) == 0);
            else           ok = jlegal[m_out];
            if (!ok) begin
                m_out = (mode == 0) ? SEED : '0;
                m_err = 1'b1;
            end else begin
                if (dir) v = ((m_out << 1) & MASK) | (((m_out >> (W-1)) & 4'd1) ^ {3'b0, mode[0]});
                else     v = (m_out >> 1) | ((((m_out & 4'd1) ^ {3'b0, mode[0]}) & 4'd1) << (W-1));
                m_out  = v;
                m_wrap = (v == ((mode == 0) ? SEED : 4'b0000));
            end
        end
    endtask

    task automatic tick(input string tag);
        if (!rst) begin
            m_out = SEED; m_wrap = 1'b0; m_err = 1'b0;
        end else begin
            mnext();
        end
        @(posedge clk);
        #1;
        chk({tag, ".out"},  32'(out),  32'(m_out));
        chk({tag, ".wrap"}, 32'(wrap), 32'(m_wrap));
        chk({tag, ".err"},  32'(err),  32'(m_err));
    endtask

    // Asynchronous pulse placed between edges; checked before any edge arrives.
    task automatic async_reset(input string tag);
        #2;
        rst = 1'b0;
        #1;
        m_out = SEED; m_wrap = 1'b0; m_err = 1'b0;
        chk({tag, ".rst_out"},  32'(out),  32'(SEED));
        chk({tag, ".rst_wrap"}, 32'(wrap), 32'd0);
        chk({tag, ".rst_err"},  32'(err),  32'd0);
        #1;
        rst = 1'b1;
    endtask

    task automatic set_in(input logic l, input logic [W-1:0] lv, input logic e,
                          input logic [1:0] m, input logic d);
        load = l; load_val = lv; en = e; mode = m; dir = d;
    endtask

    initial begin
        logic [W-1:0] v;
        v = '0;
        for (int i = 0; i < 2*W; i++) begin
            jlegal[v] = 1'b1;
            v = jshift_right(v);
        end

        #3;
        async_reset("init");

        // Ring right from seed
        set_in(0, '0, 1, 2'b00, 0);
        for (int i = 0; i < 4; i++) begin
            tick("ring_r");
            chk("ring_r.lit", 32'(out), 32'(exp29[i]));
            chk("ring_r.wlit", 32'(wrap), (i == 3) ? 32'd1 : 32'd0);
        end

        // Johnson right from all zeros
        set_in(1, 4'b0000, 0, 2'b00, 0);
        tick("jload");
        set_in(0, '0, 1, 2'b01, 0);
        for (int i = 0; i < 8; i++) begin
            tick("john_r");
            chk("john_r.lit", 32'(out), 32'(exp30[i]));
            chk("john_r.wlit", 32'(wrap), (i == 7) ? 32'd1 : 32'd0);
            chk("john_r.elit", 32'(err), 32'd0);
        end

        // Illegal ring state corrected to seed
        set_in(1, 4'b0110, 0, 2'b00, 0);
        tick("ildr");
        set_in(0, '0, 1, 2'b00, 0);
        tick("ring_fix");
        chk("ring_fix.lit", 32'(out), 32'(4'b1000));
        chk("ring_fix.elit", 32'(err), 32'd1);
        tick("ring_fix2");
        chk("ring_fix2.lit", 32'(out), 32'(4'b0100));
        chk("ring_fix2.elit", 32'(err), 32'd0);

        // Ring left, then idle hold
        async_reset("r32");
        set_in(0, '0, 1, 2'b00, 1);
        for (int i = 0; i < 4; i++) begin
            tick("ring_l");
            chk("ring_l.lit", 32'(out), 32'(exp32[i]));
        end
        chk("ring_l.wlit", 32'(wrap), 32'd1);
        set_in(0, '0, 0, 2'b00, 1);
        for (int i = 0; i < 3; i++) begin
            tick("idle");
            chk("idle.lit", 32'(out), 32'(4'b1000));
        end

        // Illegal Johnson state, then load beating en
        set_in(1, 4'b1010, 0, 2'b01, 0);
        tick("ldj");
        set_in(0, '0, 1, 2'b01, 0);
        tick("john_fix");
        chk("john_fix.lit", 32'(out), 32'(4'b0000));
        chk("john_fix.elit", 32'(err), 32'd1);
        set_in(1, 4'b0011, 1, 2'b01, 0);
        tick("ld_pri");
        chk("ld_pri.lit", 32'(out), 32'(4'b0011));
        chk("ld_pri.elit", 32'(err), 32'd0);

        // Hold modes 10/11 with en
        set_in(0, '0, 1, 2'b10, 0);
        tick("hold10");
        set_in(0, '0, 1, 2'b11, 1);
        tick("hold11");

        // Async reset mid-sequence, held low across an edge with activity
        async_reset("r34a");
        set_in(0, '0, 1, 2'b00, 0);
        tick("r34_1");
        tick("r34_2");
        chk("r34.pre", 32'(out), 32'(4'b0010));
        #2;
        rst = 1'b0;
        #1;
        chk("r34.async_out", 32'(out), 32'(SEED));
        chk("r34.async_wrap", 32'(wrap), 32'd0);
        chk("r34.async_err", 32'(err), 32'd0);
        set_in(1, 4'b0101, 1, 2'b01, 1);
        tick("rst_held");
        #2;
        rst = 1'b1;
        set_in(0, '0, 1, 2'b00, 0);
        tick("post_rst");

        // Randomized traffic
        for (int n = 0; n < 2000; n++) begin
            load     = ($urandom_range(0, 11) == 0);
            load_val = W'($urandom);
            en       = ($urandom_range(0, 3) != 0);
            mode     = 2'($urandom);
            dir      = 1'($urandom);
            if ($urandom_range(0, 99) == 0)
                async_reset("rnd");
            tick("rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
